// File: rtl/sme_ctx_seq.sv
// Context save/restore sequencer for the SME share banks.
// Walks banks 1..nb and registers 0..15, streaming bank <-> memory one word at a time.
module sme_ctx_seq #(
  parameter int XLEN = 32,
  parameter int SMAX = 4
) (
  input  logic            g_clk,
  input  logic            g_reset,
  output logic            g_clk_req,
  input  logic            start_save,
  input  logic            start_restore,
  input  logic [XLEN-1:0] base_addr,
  input  logic [3:0]      smectl_d,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [3:0]      bank_sel,
  output logic [3:0]      bank_addr,
  output logic            bank_read,
  input  logic [XLEN-1:0] bank_rdata,
  output logic            bank_wen,
  output logic [XLEN-1:0] bank_wdata,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SV_RD   = 3'd1;
  localparam logic [2:0] S_SV_WR   = 3'd2;
  localparam logic [2:0] S_RS_REQ  = 3'd3;
  localparam logic [2:0] S_RS_WAIT = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]      state;
  logic [3:0]      b, r, nb;
  logic [XLEN-1:0] base_q, data_q;
  logic            abort_q;

  logic [3:0]      nb_in;
  logic            last, abort_any;
  logic [XLEN-1:0] idx, addr;

  assign nb_in     = (smectl_d > 4'(SMAX-1)) ? 4'(SMAX-1) : smectl_d;
  assign last      = (b == nb) && (r == 4'd15);
  assign abort_any = abort | abort_q;
  // word index = (b-1)*16 + r; address arithmetic wraps at XLEN bits
  assign idx       = XLEN'({b - 4'd1, r});
  assign addr      = base_q + (idx << 2);

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state   <= S_IDLE;
      b       <= '0;
      r       <= '0;
      nb      <= '0;
      base_q  <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (start_save || start_restore) begin
            b      <= 4'd1;
            r      <= 4'd0;
            nb     <= nb_in;
            base_q <= base_addr;
            if (nb_in == 4'd0)   state <= S_DONE;
            else if (start_save) state <= S_SV_RD;
            else                 state <= S_RS_REQ;
          end
        end
        S_SV_RD: begin
          if (abort) state <= S_IDLE;
          else begin
            data_q <= bank_rdata;
            state  <= S_SV_WR;
          end
        end
        S_SV_WR: begin
          // request is never withdrawn; an abort waits for the grant
          if (mem_gnt) begin
            if (abort_any) state <= S_IDLE;
            else if (last) state <= S_DONE;
            else begin
              state <= S_SV_RD;
              if (r == 4'd15) begin r <= 4'd0; b <= b + 4'd1; end
              else r <= r + 4'd1;
            end
          end else abort_q <= abort_any;
        end
        S_RS_REQ: begin
          if (mem_gnt) state <= abort_any ? S_DRAIN : S_RS_WAIT;
          else abort_q <= abort_any;
        end
        S_RS_WAIT: begin
          if (mem_rvalid) begin
            if (abort)     state <= S_IDLE;
            else if (last) state <= S_DONE;
            else begin
              state <= S_RS_REQ;
              if (r == 4'd15) begin r <= 4'd0; b <= b + 4'd1; end
              else r <= r + 4'd1;
            end
          end else if (abort) state <= S_DRAIN;
        end
        S_DRAIN: if (mem_rvalid) state <= S_IDLE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != S_IDLE);
    g_clk_req  = busy;
    done       = (state == S_DONE);
    bank_sel   = '0;
    bank_addr  = '0;
    bank_read  = 1'b0;
    bank_wen   = 1'b0;
    bank_wdata = '0;
    mem_req    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_SV_RD: begin
        bank_read = 1'b1;
        bank_sel  = b;
        bank_addr = r;
      end
      S_SV_WR: begin
        mem_req   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = addr;
        mem_wdata = data_q;
      end
      S_RS_REQ: begin
        mem_req  = 1'b1;
        mem_addr = addr;
      end
      S_RS_WAIT: begin
        if (mem_rvalid) begin
          bank_wen   = 1'b1;
          bank_sel   = b;
          bank_addr  = r;
          bank_wdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sme_ctx_seq.sv
// Bench for sme_ctx_seq: memory/bank model with stall and read latency, scoreboard of
// expected memory and bank writes, table of whole operations plus abort/reset sequences.
module tb_sme_ctx_seq;

  logic        g_clk = 1'b0;
  logic        g_reset, g_clk_req, start_save, start_restore, abort;
  logic [31:0] base_addr;
  logic [3:0]  smectl_d;
  logic        busy, done, bank_read, bank_wen, mem_req, mem_wen;
  logic [3:0]  bank_sel, bank_addr;
  logic [31:0] bank_rdata, bank_wdata, mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 g_clk = ~g_clk;

  sme_ctx_seq #(.XLEN(32), .SMAX(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req),
    .start_save(start_save), .start_restore(start_restore),
    .base_addr(base_addr), .smectl_d(smectl_d), .abort(abort),
    .busy(busy), .done(done), .bank_sel(bank_sel), .bank_addr(bank_addr),
    .bank_read(bank_read), .bank_rdata(bank_rdata), .bank_wen(bank_wen),
    .bank_wdata(bank_wdata), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] bank_val(input int bk, input int rg);
    return 32'hA0 + 32'(rg) + 32'(bk - 1) * 32'h100;
  endfunction

  assign bank_rdata = bank_val(int'(bank_sel), int'(bank_addr));

  logic [110:0] outs;
  assign outs = {busy, done, g_clk_req, bank_read, bank_wen, mem_req, mem_wen,
                 bank_sel, bank_addr, mem_addr, mem_wdata, bank_wdata};

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  logic [63:0] exp_mem[$];   // {addr, data}
  logic [39:0] exp_bank[$];  // {sel, addr, data}

  int          rd_lat = 1, rd_cnt = 0, stall_left = 0;
  logic [31:0] stall_addr = '0, rd_data = '0;
  int          n_acc = 0, n_read = 0, n_done = 0;
  logic        prev_stall = 1'b0, prev_wacc = 1'b0, prev_wen = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  // memory side: grant/stall decision and read return, then scoreboard the cycle
  always @(negedge g_clk) begin
    mem_rvalid = 1'b0;
    if (g_reset) begin
      rd_cnt = 0; mem_gnt = 1'b0; prev_stall = 1'b0; prev_wacc = 1'b0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rd_data; end
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
        if (stall_left > 0 && mem_addr == stall_addr) stall_left--;
        else begin
          mem_gnt = 1'b1;
          if (!mem_wen) begin rd_cnt = rd_lat; rd_data = mem_addr; end
        end
      end
      #1;
      if (mem_req && mem_gnt) begin
        n_acc++;
        if (mem_wen) begin
          if (exp_mem.size() == 0) chk("mem_unexpected", {mem_addr, mem_wdata}, 0);
          else chk("mem_write", {mem_addr, mem_wdata}, exp_mem.pop_front());
        end
      end
      if (bank_read) n_read++;
      if (bank_wen) begin
        if (exp_bank.size() == 0) chk("bank_unexpected", {bank_sel, bank_addr, bank_wdata}, 0);
        else chk("bank_write", {bank_sel, bank_addr, bank_wdata}, exp_bank.pop_front());
      end
      if (done) n_done++;
      if (prev_stall)
        chk("stall_hold", {mem_req, mem_wen, mem_addr, mem_wdata},
            {1'b1, prev_wen, prev_addr, prev_wdata});
      if (prev_wacc && busy && !done) chk("read_after_gnt", bank_read, 1'b1);
      prev_stall = mem_req && !mem_gnt;
      prev_wacc  = mem_req && mem_gnt && mem_wen;
      prev_wen   = mem_wen;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  typedef struct {
    logic        sv;
    logic        rs;
    logic [3:0]  d;
    logic [31:0] base;
    int          lat;
    int          stall;
    int          exp_cyc;
  } vec_t;
  vec_t tbl[8];

  task automatic run(input vec_t v);
    int cyc, nb, a0, r0, d0;
    logic [31:0] a;
    nb = (v.d > 4'd3) ? 3 : int'(v.d);
    for (int bk = 1; bk <= nb; bk++)
      for (int rg = 0; rg < 16; rg++) begin
        a = v.base + 32'(((bk - 1) * 16 + rg) * 4);
        if (v.sv) exp_mem.push_back({a, bank_val(bk, rg)});
        else      exp_bank.push_back({4'(bk), 4'(rg), a});
      end
    rd_lat = v.lat; stall_left = v.stall; stall_addr = v.base + 32'd4;
    a0 = n_acc; r0 = n_read; d0 = n_done;
    @(posedge g_clk); #2;
    start_save = v.sv; start_restore = v.rs; smectl_d = v.d; base_addr = v.base;
    @(posedge g_clk); #2;
    start_save = 1'b0; start_restore = 1'b0; cyc = 1;
    while (!done && cyc < 2000) begin @(posedge g_clk); #2; cyc++; end
    chk("done_latency", cyc, v.exp_cyc);
    @(posedge g_clk); #2;
    chk("after_done", {done, busy}, 2'b00);
    chk("mem_q_empty", exp_mem.size(), 0);
    chk("bank_q_empty", exp_bank.size(), 0);
    chk("mem_accepts", n_acc - a0, 16 * nb);
    chk("bank_reads", n_read - r0, v.sv ? 16 * nb : 0);
    chk("done_count", n_done - d0, 1);
  endtask

  initial begin
    int k;
    logic seen;
    int bw0, dn0;
    vec_t v;
    tbl[0] = '{1'b1, 1'b0, 4'd1, 32'h0000_1000, 1, 0, 33};
    tbl[1] = '{1'b0, 1'b1, 4'd3, 32'h0000_2000, 2, 0, 145};
    tbl[2] = '{1'b1, 1'b0, 4'd0, 32'h0000_1000, 1, 0, 1};
    tbl[3] = '{1'b1, 1'b0, 4'd1, 32'h0000_1000, 1, 5, 38};
    tbl[4] = '{1'b1, 1'b0, 4'd7, 32'h0000_0500, 1, 0, 97};
    tbl[5] = '{1'b0, 1'b1, 4'd2, 32'h0000_8000, 1, 0, 65};
    tbl[6] = '{1'b0, 1'b1, 4'd0, 32'h0000_9000, 1, 0, 1};
    tbl[7] = '{1'b1, 1'b0, 4'd1, 32'hFFFF_FFF0, 1, 0, 33};

    g_reset = 1'b1; start_save = 1'b0; start_restore = 1'b0; abort = 1'b0;
    base_addr = '0; smectl_d = '0;
    repeat (3) @(posedge g_clk);
    #2;
    chk("reset_outputs", outs, 0);
    g_reset = 1'b0;

    for (int i = 0; i < 8; i++) run(tbl[i]);

    // abort while waiting for read data: drain the orphan rvalid, no bank write, no done
    bw0 = n_done; dn0 = exp_bank.size();
    rd_lat = 4; stall_left = 0;
    @(posedge g_clk); #2;
    smectl_d = 4'd1; base_addr = 32'h3000; start_restore = 1'b1;
    @(posedge g_clk); #2;
    start_restore = 1'b0;
    chk("abort_req", {busy, mem_req, mem_wen}, 3'b110);
    @(posedge g_clk); #2;
    abort = 1'b1;
    chk("abort_in_wait", {busy, mem_req}, 2'b10);
    @(posedge g_clk); #2;
    abort = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge g_clk); #2;
      chk("abort_busy", {busy, bank_wen, done}, 3'b100);
      seen = mem_rvalid; k++;
    end
    chk("abort_rvalid_seen", seen, 1'b1);
    @(posedge g_clk); #2;
    chk("abort_idle", busy, 1'b0);
    chk("abort_no_done", n_done - bw0, 0);
    chk("abort_bank_q", exp_bank.size(), dn0);

    // both starts together: save wins; then reset mid-save
    rd_lat = 1;
    exp_mem.push_back({32'h4000, bank_val(1, 0)});
    exp_mem.push_back({32'h4004, bank_val(1, 1)});
    @(posedge g_clk); #2;
    smectl_d = 4'd1; base_addr = 32'h4000; start_save = 1'b1; start_restore = 1'b1;
    @(posedge g_clk); #2;
    start_save = 1'b0; start_restore = 1'b0;
    chk("both_first_read", {bank_read, mem_req}, 2'b10);
    @(posedge g_clk); #2;
    chk("both_is_save", {mem_req, mem_wen, mem_addr}, {2'b11, 32'h4000});
    repeat (3) begin @(posedge g_clk); #2; end
    g_reset = 1'b1;
    @(posedge g_clk); #2;
    g_reset = 1'b0;
    chk("midreset_outputs", outs, 0);
    chk("midreset_mem_q", exp_mem.size(), 0);
    v = '{1'b0, 1'b1, 4'd1, 32'h0000_6000, 1, 0, 33};
    run(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
